// File: rtl/mult_pkg.sv
// Purpose: shared helpers for the array multiplier family (pipeline depth calculation).
// Latency: n/a (constant functions only, no logic).
// Backpressure: n/a.
package mult_pkg;

   // Number of register ranks for a given width and rows-per-stage (ceiling division).
   function automatic int stages_f(input int width, input int rows);
      return (width + rows - 1) / rows;
   endfunction

endpackage

// File: rtl/mult_row.sv
// Purpose: one row of the unsigned array multiplier; adds (x & {N{y_bit}}) << ROW into the running sum.
// Latency: purely combinational, a ripple chain of WIDTH full-adder cells.
// Backpressure: none; the enclosing pipeline owns flow control.
module mult_row
#(
   parameter int WIDTH = 8,
   parameter int ROW   = 0
) (
   input  logic [2*WIDTH-1:0] sum_in,
   input  logic [WIDTH-1:0]   x,
   input  logic               y_bit,
   output logic [2*WIDTH-1:0] sum_out
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] cell_sum;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic pp;
      logic a;
      assign pp            = x[i] & y_bit;
      assign a             = sum_in[ROW+i];
      assign cell_sum[i]   = a ^ pp ^ carry[i];
      assign carry[i+1]    = (a & pp) | (a & carry[i]) | (pp & carry[i]);
   end

   // Bits below ROW pass through; bits above ROW+WIDTH are still zero at this row, so
   // the row carry-out simply lands in bit ROW+WIDTH.
   always_comb begin
      sum_out                  = sum_in;
      sum_out[ROW +: WIDTH]    = cell_sum;
      sum_out[ROW+WIDTH]       = carry[WIDTH];
   end

endmodule

// File: rtl/array_mult_pipe.sv
// Purpose: pipelined unsigned array multiplier, ROWS_PER_STAGE rows per rank, tag carried alongside.
// Latency: STAGES cycles from accept edge to out_valid; one product per cycle sustained.
// Backpressure: whole pipe freezes (bubbles included) when out_valid & !out_ready; in_ready follows.
module array_mult_pipe
   import mult_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int ROWS_PER_STAGE = 2,
   parameter int TAG_W          = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [WIDTH-1:0]   in_y,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int STAGES = stages_f(WIDTH, ROWS_PER_STAGE);
   localparam int PW     = 2 * WIDTH;

   logic             advance;

   // Rank registers.
   logic             vld_q [STAGES];
   logic [PW-1:0]    sum_q [STAGES];
   logic [WIDTH-1:0] x_q   [STAGES];
   logic [WIDTH-1:0] y_q   [STAGES];
   logic [TAG_W-1:0] tag_q [STAGES];

   // Next-state for each rank: stage inputs forwarded, sum computed by the stage rows.
   logic             vld_d [STAGES];
   logic [PW-1:0]    sum_d [STAGES];
   logic [WIDTH-1:0] x_d   [STAGES];
   logic [WIDTH-1:0] y_d   [STAGES];
   logic [TAG_W-1:0] tag_d [STAGES];

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [PW-1:0] chain [ROWS_PER_STAGE+1];

      if (s == 0) begin : g_src
         assign vld_d[s] = in_valid;
         assign x_d[s]   = in_x;
         assign y_d[s]   = in_y;
         assign tag_d[s] = in_tag;
         assign chain[0] = '0;
      end else begin : g_src
         assign vld_d[s] = vld_q[s-1];
         assign x_d[s]   = x_q[s-1];
         assign y_d[s]   = y_q[s-1];
         assign tag_d[s] = tag_q[s-1];
         assign chain[0] = sum_q[s-1];
      end

      // The last stage may hold fewer rows when WIDTH is not a multiple of ROWS_PER_STAGE.
      for (genvar r = 0; r < ROWS_PER_STAGE; r++) begin : g_row
         if (s * ROWS_PER_STAGE + r < WIDTH) begin : g_cell
            mult_row #(
               .WIDTH (WIDTH),
               .ROW   (s * ROWS_PER_STAGE + r)
            ) u_row (
               .sum_in  (chain[r]),
               .x       (x_d[s]),
               .y_bit   (y_d[s][s*ROWS_PER_STAGE+r]),
               .sum_out (chain[r+1])
            );
         end else begin : g_pass
            assign chain[r+1] = chain[r];
         end
      end

      assign sum_d[s] = chain[ROWS_PER_STAGE];
   end

   assign out_valid = vld_q[STAGES-1];
   assign out_p     = sum_q[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];
   assign advance   = !out_valid | out_ready;
   assign in_ready  = advance & !rst;

   // Operands in the final rank have no consumer downstream.
   logic unused_last_rank;
   assign unused_last_rank = ^{x_q[STAGES-1], y_q[STAGES-1]};

   // All ranks shift together on advance and hold together otherwise; reset empties the pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            vld_q[s] <= 1'b0;
            sum_q[s] <= '0;
            x_q[s]   <= '0;
            y_q[s]   <= '0;
            tag_q[s] <= '0;
         end
      end else if (advance) begin
         for (int s = 0; s < STAGES; s++) begin
            vld_q[s] <= vld_d[s];
            sum_q[s] <= sum_d[s];
            x_q[s]   <= x_d[s];
            y_q[s]   <= y_d[s];
            tag_q[s] <= tag_d[s];
         end
      end
   end

endmodule

// File: tb/tb_array_mult_pipe.sv
// Purpose: self-checking bench for array_mult_pipe (8x8 / 2 rows per stage, plus a 7x7 / 3 rows instance).
// Latency: checks accept-to-valid depth, stall holding, reset flush and a random stream.
// Backpressure: drives out_ready low in directed and random patterns.
module tb_array_mult_pipe;
   import mult_pkg::*;

   localparam int W     = 8;
   localparam int R     = 2;
   localparam int TW    = 4;
   localparam int ST    = stages_f(W, R);
   localparam int BW    = 7;
   localparam int BR    = 3;
   localparam int BST   = stages_f(BW, BR);
   localparam int NRAND = 10000;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]    in_x, in_y;
   logic [TW-1:0]   in_tag, out_tag;
   logic [2*W-1:0]  out_p;

   logic            b_in_valid, b_in_ready, b_out_valid;
   logic [BW-1:0]   b_in_x, b_in_y;
   logic [TW-1:0]   b_in_tag, b_out_tag;
   logic [2*BW-1:0] b_out_p;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_p [$];
   int exp_t [$];

   always #5 clk = ~clk;

   array_mult_pipe #(.WIDTH(W), .ROWS_PER_STAGE(R), .TAG_W(TW)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_p(out_p), .out_tag(out_tag)
   );

   array_mult_pipe #(.WIDTH(BW), .ROWS_PER_STAGE(BR), .TAG_W(TW)) u_dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_x(b_in_x), .in_y(b_in_y), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(1'b1),
      .out_p(b_out_p), .out_tag(b_out_tag)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: inputs are stable at the falling edge, so handshakes seen here complete at the next rise.
   always @(negedge clk) begin
      if (rst) begin
         exp_p.delete();
         exp_t.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_p.size() == 0) begin
               chk("sb_unexpected_beat", out_p, -1);
            end else begin
               chk("sb_p", out_p, exp_p.pop_front());
               chk("sb_tag", out_tag, exp_t.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            exp_p.push_back(int'(in_x) * int'(in_y));
            exp_t.push_back(int'(in_tag));
         end
      end
   end

   task automatic one_pair(input string tg, input int x, input int y, input int t, input int p);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_x = W'(x); in_y = W'(y); in_tag = TW'(t);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < ST; k++) begin
         chk({tg, "_vld"}, out_valid, (k == ST-1) ? 1 : 0);
         if (k < ST-1) step();
      end
      chk({tg, "_p"}, out_p, p);
      chk({tg, "_tag"}, out_tag, t);
      step();
      chk({tg, "_one_beat"}, out_valid, 0);
   endtask

   initial begin
      int k, i, held, sent, cyc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_x = '0; in_y = '0; in_tag = '0;
      b_in_valid = 1'b0; b_in_x = '0; b_in_y = '0; b_in_tag = '0;

      // Reset state.
      step(); step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_p", out_p, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      step();

      // Single pair, all-ones corner.
      one_pair("t1", 255, 255, 5, 16'hFE01);

      // Back-to-back stream, no stall.
      k = 0;
      for (int c = 0; c < 40 && k < 16; c++) begin
         in_valid = (c < 16); in_x = W'(c); in_y = W'(c+1); in_tag = TW'(c);
         #1;
         if (c < 16) chk("t2_in_ready", in_ready, 1);
         if (out_valid) begin
            chk("t2_p", out_p, k * (k+1));
            k++;
         end else if (k > 0) begin
            chk("t2_gap", out_valid, 1);
         end
         step();
      end
      in_valid = 1'b0;
      chk("t2_count", k, 16);
      step();

      // Stream with a 3-cycle consumer stall mid-way.
      k = 0; i = 0; held = 0;
      for (int c = 0; c < 40 && k < 16; c++) begin
         out_ready = !(c >= 8 && c < 11);
         in_valid = (i < 16); in_x = W'(i); in_y = W'(i+1); in_tag = TW'(i);
         #1;
         if (c == 8) held = int'(out_p);
         if (!out_ready) begin
            chk("t3_in_ready_low", in_ready, 0);
            chk("t3_out_valid_held", out_valid, 1);
            chk("t3_out_p_held", out_p, held);
         end
         if (out_valid && out_ready) begin
            chk("t3_p", out_p, k * (k+1));
            k++;
         end
         if (in_valid && in_ready) i++;
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("t3_count", k, 16);
      chk("t3_accepted", i, 16);
      step();

      // Reset with three pairs in flight.
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; in_x = W'(10+c); in_y = W'(20+c); in_tag = TW'(c+1);
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      chk("t4_out_valid", out_valid, 0);
      chk("t4_out_p", out_p, 0);
      chk("t4_out_tag", out_tag, 0);
      chk("t4_in_ready_in_rst", in_ready, 0);
      rst = 1'b0;
      for (int c = 0; c < ST+2; c++) begin
         #1;
         chk("t4_no_ghost", out_valid, 0);
         step();
      end

      // Zero / one / power-of-two corners.
      one_pair("t5_zero", 0, 200, 1, 0);
      one_pair("t5_one", 1, 173, 2, 173);
      one_pair("t5_pow2", 128, 2, 3, 256);

      // 7-bit instance with a remainder stage.
      b_in_valid = 1'b1; b_in_x = 7'd127; b_in_y = 7'd127; b_in_tag = 4'd9;
      step();
      b_in_valid = 1'b0;
      for (int c = 0; c < BST; c++) begin
         chk("t5b_vld", b_out_valid, (c == BST-1) ? 1 : 0);
         if (c < BST-1) step();
      end
      chk("t5b_p", b_out_p, 16129);
      chk("t5b_tag", b_out_tag, 9);
      step();

      // Random stream with random backpressure; scoreboard does the checking.
      sent = 0; cyc = 0;
      while (sent < NRAND && cyc < 60000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_x = W'($urandom); in_y = W'($urandom); in_tag = TW'($urandom);
         #1;
         if (in_valid && in_ready) sent++;
         step();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("t6_sent", sent, NRAND);
      repeat (ST + 2) step();
      chk("t6_drained", exp_p.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
